// File: rtl/spi_frame_seq_if.sv
// Sample-stream and SPI-engine signals between the frame sequencer and its neighbours.
// master is the sequencer's view; slave is the view of the source/engine side.
interface spi_frame_seq_if;
    logic [15:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic        spi_start;
    logic [7:0]  spi_tdat;
    logic [1:0]  spi_cdiv;
    logic        spi_mlb;
    logic        spi_done;

    modport master (
        input  s_data, s_valid, spi_done,
        output s_ready, spi_start, spi_tdat, spi_cdiv, spi_mlb
    );

    modport slave (
        output s_data, s_valid, spi_done,
        input  s_ready, spi_start, spi_tdat, spi_cdiv, spi_mlb
    );
endinterface

// File: rtl/spi_frame_seq.sv
// Buffers 16-bit samples and issues 3-byte DAC frames (command, MSB, LSB) to an SPI engine,
// one start per byte, with an inter-byte gap and a per-byte done timeout.
module spi_frame_seq #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned GAP        = 8,
    parameter int unsigned TIMEOUT    = 1024,
    parameter logic [7:0]  CMD_BYTE   = 8'h30
) (
    input  logic                  clk,
    input  logic                  rstb,
    spi_frame_seq_if.master       bus,
    input  logic                  cfg_en,
    input  logic [1:0]            cfg_cdiv,
    input  logic                  err_clr,
    output logic                  busy,
    output logic [15:0]           frames_sent,
    output logic                  err
);

    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned GW = (GAP > 1) ? $clog2(GAP) : 1;
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_WAIT,
        S_GAP
    } state_t;

    state_t          state_q, state_d;
    logic [15:0]     mem_q [FIFO_DEPTH];
    logic [PW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            s_ready_q, s_ready_d;
    logic [15:0]     samp_q, samp_d;
    logic [1:0]      idx_q, idx_d;
    logic [1:0]      cdiv_q, cdiv_d;
    logic [7:0]      tdat_q, tdat_d;
    logic            start_q, start_d;
    logic            seen_q, seen_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic [GW-1:0]   gap_q, gap_d;
    logic            ended_q, ended_d;
    logic [15:0]     frames_q, frames_d;
    logic            err_q, err_d;
    logic            busy_q, busy_d;
    logic            push_c, pop_c, err_set_c;

    assign push_c = bus.s_valid && s_ready_q;

    // Sample storage; pointers alone define occupancy, so the array needs no reset.
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem_q[wptr_q] <= bus.s_data;
        end
    end

    always_comb begin
        wptr_d    = push_c ? wptr_q + PW'(1) : wptr_q;
        rptr_d    = pop_c ? rptr_q + PW'(1) : rptr_q;
        count_d   = count_q + CW'(push_c) - CW'(pop_c);
        s_ready_d = (count_d != CW'(FIFO_DEPTH));
    end

    always_comb begin
        state_d   = state_q;
        samp_d    = samp_q;
        idx_d     = idx_q;
        cdiv_d    = cdiv_q;
        tdat_d    = tdat_q;
        start_d   = 1'b0;
        seen_d    = seen_q;
        tmo_d     = tmo_q;
        gap_d     = gap_q;
        ended_d   = ended_q;
        frames_d  = frames_q;
        err_set_c = 1'b0;
        pop_c     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (cfg_en && (count_q != '0)) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                pop_c   = 1'b1;
                samp_d  = mem_q[rptr_q];
                cdiv_d  = cfg_cdiv;
                idx_d   = 2'd0;
                ended_d = 1'b0;
                state_d = S_START;
            end
            S_START: begin
                seen_d  = 1'b0;
                tmo_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (!bus.spi_done) begin
                    seen_d = 1'b1;
                end
                // A done level that was never seen low is the previous byte's stale high.
                if (bus.spi_done && seen_q) begin
                    gap_d   = '0;
                    state_d = S_GAP;
                    if (idx_q == 2'd2) begin
                        frames_d = frames_q + 16'd1;
                        ended_d  = 1'b1;
                    end
                end else begin
                    tmo_d = tmo_q + TW'(1);
                    if (tmo_d == TW'(TIMEOUT)) begin
                        err_set_c = 1'b1;
                        ended_d   = 1'b1;
                        gap_d     = '0;
                        state_d   = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (gap_q == GW'(GAP - 1)) begin
                    if (ended_q) begin
                        state_d = S_IDLE;
                    end else begin
                        idx_d   = idx_q + 2'd1;
                        state_d = S_START;
                    end
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Byte and start pulse are registered on entry to START so they line up with it.
        if ((state_d == S_START) && (state_q != S_START)) begin
            start_d = 1'b1;
            unique case (idx_d)
                2'd0:    tdat_d = CMD_BYTE;
                2'd1:    tdat_d = samp_d[15:8];
                default: tdat_d = samp_d[7:0];
            endcase
        end
    end

    always_comb begin
        err_d  = err_set_c ? 1'b1 : (err_clr ? 1'b0 : err_q);
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q   <= S_IDLE;
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
            s_ready_q <= 1'b1;
            samp_q    <= '0;
            idx_q     <= '0;
            cdiv_q    <= '0;
            tdat_q    <= '0;
            start_q   <= 1'b0;
            seen_q    <= 1'b0;
            tmo_q     <= '0;
            gap_q     <= '0;
            ended_q   <= 1'b0;
            frames_q  <= '0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            count_q   <= count_d;
            s_ready_q <= s_ready_d;
            samp_q    <= samp_d;
            idx_q     <= idx_d;
            cdiv_q    <= cdiv_d;
            tdat_q    <= tdat_d;
            start_q   <= start_d;
            seen_q    <= seen_d;
            tmo_q     <= tmo_d;
            gap_q     <= gap_d;
            ended_q   <= ended_d;
            frames_q  <= frames_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.s_ready   = s_ready_q;
    assign bus.spi_start = start_q;
    assign bus.spi_tdat  = tdat_q;
    assign bus.spi_cdiv  = cdiv_q;
    assign bus.spi_mlb   = 1'b1;
    assign busy          = busy_q;
    assign frames_sent   = frames_q;
    assign err           = err_q;

endmodule

// File: doc/spi_frame_seq.md
# spi_frame_seq

Frame sequencer that sits in front of `spi_master` and turns a stream of 16-bit audio samples into 3-byte SPI DAC frames: command byte, sample MSB, sample LSB. It buffers samples in a small FIFO, issues one `start` per byte, waits for the engine's `done`, enforces an inter-byte gap, and flags hung transfers with a timeout. All sequencing runs in the `clk` domain.

## Interface
- FIFO_DEPTH, 4: sample FIFO entries (power of 2, ≥2)
- GAP, 8: idle `clk` cycles after every byte (≥1)
- TIMEOUT, 1024: max `clk` cycles waiting for `done` per byte
- CMD_BYTE, 8'h30: first byte of every frame

- clk  in  1  system clock; all logic on posedge
- rstb  in  1  asynchronous active-low reset
- s_data  in  16  sample in
- s_valid  in  1  sample valid
- s_ready  out  1  FIFO not full
- cfg_en  in  1  enable frame issue
- cfg_cdiv  in  2  clock divider for the next frame
- err_clr  in  1  clears `err`
- spi_start  out  1  one-cycle start pulse to engine
- spi_tdat  out  8  byte to transmit
- spi_cdiv  out  2  divider to engine, latched per frame
- spi_mlb  out  1  constant 1 (MSB first)
- spi_done  in  1  engine byte-complete (level)
- busy  out  1  FSM not in IDLE
- frames_sent  out  16  completed-frame counter
- err  out  1  sticky timeout flag

## Operation
- FIFO: push when `s_valid && s_ready`; `s_ready = (count != FIFO_DEPTH)`. Push and pop in the same cycle leave `count` unchanged. No overwrite when full; no pop when empty.
- FSM states: IDLE, LOAD, START, WAIT, GAP.
  - IDLE: if `cfg_en && count != 0`, go to LOAD.
  - LOAD: pop head into `samp`, latch `cfg_cdiv` into `spi_cdiv`, set `idx = 0`, go to START.
  - START: `spi_start = 1` for this cycle only. `spi_tdat` = CMD_BYTE / `samp[15:8]` / `samp[7:0]` for `idx` 0/1/2. Clear `seen_low` and the timeout counter, go to WAIT.
  - WAIT: set `seen_low` when `spi_done == 0`. Byte is complete on the first cycle with `spi_done == 1 && seen_low`; then go to GAP. If `idx == 2`, also increment `frames_sent` and mark the frame ended. Otherwise increment the timeout counter; when it reaches TIMEOUT, set `err`, mark the frame ended, and go to GAP.
  - GAP: count GAP cycles. Then go to IDLE if the frame ended; otherwise `idx++` and go to START.
- `spi_tdat` and `spi_cdiv` hold stable from START until the next START/LOAD.
- `cfg_en` is sampled only in IDLE. Deasserting it mid-frame lets the frame finish.
- `cfg_cdiv` changes mid-frame take effect at the next LOAD.
- `err`: set by timeout, cleared by `err_clr`. If set and clear happen in the same cycle, set wins. A timed-out frame's remaining bytes are dropped and `frames_sent` is not incremented.
- `frames_sent` wraps 16'hFFFF → 0.

## Timing
- Reset values: `spi_start = 0`, `spi_tdat = 0`, `spi_cdiv = 0`, `spi_mlb = 1`, `busy = 0`, `frames_sent = 0`, `err = 0`, FIFO empty, `s_ready = 1`, FSM in IDLE.
- Reset mid-frame: return immediately to these values; FIFO contents are discarded.
- Latency: sample pushed at edge N into an empty FIFO with the FSM idle and `cfg_en = 1`:
  - LOAD in cycle N+1;
  - `spi_start` high in cycle N+2.
- Per byte: 1 (START) + engine time + GAP cycles.
- Frame-to-frame: the next START comes 2 cycles (IDLE, LOAD) after the last GAP cycle.
- `busy` is high from LOAD through the last GAP cycle.
- `spi_done` is ignored until it has been sampled low at least once after START. This rejects the stale high left over from the previous byte.

## Test plan
- **Reset:** `rstb` low with `s_valid` high → all reset values hold; `s_ready = 1` after release.
- **Single frame:** push 16'hA55A with an engine model that gives `done` 40 cycles after start → bytes 8'h30, 8'hA5, 8'h5A in order. Exactly 3 `spi_start` pulses, each 1 cycle wide, starts spaced by 41 + GAP cycles. `frames_sent = 1`, `busy` low afterwards.
- **FIFO full / back-to-back:** hold `cfg_en = 0` and push 5 samples → `s_ready` drops after the 4th and the 5th is held off. Set `cfg_en = 1` → 4 frames sent in FIFO order and `s_ready` reasserts after the first LOAD.
- **Stale done:** engine holds `done = 1` after byte 1 and only drops it 3 cycles after the next start → the FSM stays in WAIT until `done` goes 0 then 1; no byte is skipped.
- **Timeout:** engine never asserts `done` on byte 2 → `err = 1` at TIMEOUT cycles, byte 3 is not started, `frames_sent` unchanged, the next frame proceeds. Assert `err_clr` and a timeout in the same cycle → `err` stays 1.
- **Config / wrap:** change `cfg_cdiv` 0→3 mid-frame → `spi_cdiv` changes only at the next frame. Preload `frames_sent` to 16'hFFFF via force and complete one frame → reads 0.
